memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares the single-ported RAM between the instruction-fetch and data-access request paths.
//  Sits between the datapath/cache request side and the RAM.
//  Sequences one RAM transaction at a time with a registered grant FSM.
//  Data requests have priority; a starvation counter guarantees forward progress for fetch.
// PARAMETERS
//  DSTREAK_MAX  4   max consecutive data grants while an instruction request waits (>=1)
//  ADDR_W       32  address/data width (word_t)
// PORTS
//  CLK       in   1       system clock, all state updates on posedge
//  nRST      in   1       reset: synchronous, active-high (1 = reset on next posedge)
//  iREN      in   1       instruction read request, held until iwait=0
//  iaddr     in   ADDR_W  instruction address
//  iwait     out  1       1 = instruction request not yet complete
//  iload     out  ADDR_W  instruction read data, valid when iREN & !iwait
//  dREN      in   1       data read request, held until dwait=0
//  dWEN      in   1       data write request (dREN&dWEN both 1: treat as write)
//  daddr     in   ADDR_W  data address
//  dstore    in   ADDR_W  data write value
//  dwait     out  1       1 = data request not yet complete
//  dload     out  ADDR_W  data read value, valid when dREN & !dwait
//  ramREN    out  1       RAM read strobe
//  ramWEN    out  1       RAM write strobe
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  ADDR_W  RAM write data
//  ramload   in   ADDR_W  RAM read data
//  ramstate  in   2       0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//  ram_err   out  1       sticky: set when ramstate==ERROR seen during a grant
// BEHAVIOUR
//  FSM states IDLE, IGNT, DGNT (state register only; all outputs combinational from state+inputs).
//  IDLE: RAM strobes 0; iwait=iREN, dwait=(dREN|dWEN).
//   - Arbitrate on the posedge.
//   - If data pending and (!iREN or dstreak<DSTREAK_MAX): go to DGNT.
//   - Else if iREN: go to IGNT. Else stay in IDLE.
//  DGNT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN.
//   - When ramstate==ACCESS: dwait=0 in that same cycle, dload=ramload; next state IDLE.
//   - Otherwise dwait=1.
//  IGNT: same as DGNT with ramaddr=iaddr, ramREN=1, ramWEN=0, iload=ramload; iwait cleared on ACCESS.
//  Non-granted requester always sees wait=1 (if requesting); load outputs are 0 when not granted.
//  Latency: a request seen in IDLE at edge N gets RAM strobes from cycle N+1.
//   - Completion is the cycle ramstate==ACCESS. Min 2 cycles request-to-done.
//   - One mandatory IDLE cycle after each completion (no back-to-back grant).
//  BUSY/FREE during a grant: hold state and strobes.
//  ERROR during a grant: hold state (retry) and set ram_err; ram_err clears only on reset.
//  Abort: if the granted requester drops its request before ACCESS, strobes go 0 that cycle.
//   - Next state is IDLE; no completion is signalled.
//  dstreak (width clog2(DSTREAK_MAX+1)), saturating, updated on IDLE->grant edges:
//   - IDLE->DGNT with iREN=1: increment.
//   - IDLE->IGNT, or iREN=0 at that edge: clear to 0.
//  Reset (any state, mid-transaction included): state=IDLE, dstreak=0, ram_err=0.
//   - Therefore the strobes are 0 in the cycle after the reset edge.
//   - While reset is asserted, outputs follow IDLE rules.
// TESTING
//  1 iREN=1 iaddr=0x100, RAM returns ACCESS 2 cycles after strobe, ramload=0xDEADBEEF
//    -> ramREN=1 from cycle 1; iload=0xDEADBEEF and iwait=0 at cycle 3; IDLE at cycle 4.
//  2 iREN and dWEN both raised in the same cycle (daddr=0x40, dstore=0x12345678)
//    -> DGNT first, RAM write 0x12345678 @0x40; then IDLE, then IGNT.
//  3 iREN held with continuous dREN requests, DSTREAK_MAX=4
//    -> 4 data grants, then exactly 1 IGNT, then data resumes.
//  4 ramstate=ERROR for 3 cycles, then ACCESS during DGNT
//    -> ram_err=1 stays set; dwait=0 only on the ACCESS cycle; strobes held throughout.
//  5 nRST=1 asserted while in IGNT with ramstate=BUSY
//    -> next cycle ramREN=0, ramWEN=0, iwait=iREN, ram_err=0, dstreak=0.
//  6 dREN dropped mid-DGNT (ramstate=BUSY)
//    -> strobes 0 that cycle, IDLE next, no completion signalled.

Source files
------------

// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access.
// Data requests have priority, but a streak counter makes sure a waiting fetch is eventually served.
module memory_arbiter #(
   parameter int DSTREAK_MAX = 4,
   parameter int ADDR_W      = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [ADDR_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [ADDR_W-1:0] dstore,
   output logic              dwait,
   output logic [ADDR_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [ADDR_W-1:0] ramstore,
   input  logic [ADDR_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              ram_err
);
   // state | meaning
   // IDLE  | no RAM transaction; arbitrate on the next edge
   // IGNT  | RAM owned by instruction fetch until ACCESS or abort
   // DGNT  | RAM owned by data access until ACCESS or abort
   typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

   localparam int          SW        = $clog2(DSTREAK_MAX + 1);
   localparam logic [SW-1:0] SMAX    = SW'(DSTREAK_MAX);
   localparam logic [1:0]  RS_ACCESS = 2'd2;
   localparam logic [1:0]  RS_ERROR  = 2'd3;

   state_t        state, state_n, cur;
   logic [SW-1:0] dstreak, dstreak_n;
   logic          dpend, err_set;

   always_comb begin
      dpend     = dREN | dWEN;
      // Holding reset makes the outputs follow the IDLE rules immediately.
      cur       = nRST ? IDLE : state;
      state_n   = cur;
      dstreak_n = dstreak;
      err_set   = 1'b0;
      iwait     = iREN;
      dwait     = dpend;
      iload     = '0;
      dload     = '0;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = '0;
      ramstore  = '0;
      case (cur)
         IDLE: begin
            if (dpend && (!iREN || dstreak < SMAX)) begin
               state_n = DGNT;
               if (!iREN)
                  dstreak_n = '0;
               else if (dstreak != SMAX)
                  dstreak_n = dstreak + SW'(1);
            end else if (iREN) begin
               state_n   = IGNT;
               dstreak_n = '0;
            end
         end
         IGNT: begin
            if (!iREN) begin
               state_n = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ramstate == RS_ACCESS) begin
                  iwait   = 1'b0;
                  iload   = ramload;
                  state_n = IDLE;
               end else if (ramstate == RS_ERROR) begin
                  err_set = 1'b1;
               end
            end
         end
         DGNT: begin
            if (!dpend) begin
               state_n = IDLE;
            end else begin
               ramWEN   = dWEN;
               ramREN   = dREN & ~dWEN;
               ramaddr  = daddr;
               ramstore = dstore;
               if (ramstate == RS_ACCESS) begin
                  dwait   = 1'b0;
                  dload   = ramload;
                  state_n = IDLE;
               end else if (ramstate == RS_ERROR) begin
                  err_set = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (nRST) begin
         state   <= IDLE;
         dstreak <= '0;
         ram_err <= 1'b0;
      end else begin
         state   <= state_n;
         dstreak <= dstreak_n;
         if (err_set)
            ram_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: ownership model checked every cycle, plus directed scenarios
// with hand-computed expectations and a simple latency-programmable RAM responder.
module tb_memory_arbiter;
   localparam int DMAX = 4;

   logic        CLK = 1'b0, nRST = 1'b1;
   logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
   logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
   logic [1:0]  ramstate = 2'd0;
   logic        iwait, dwait, ramREN, ramWEN, ram_err;
   logic [31:0] iload, dload, ramaddr, ramstore;

   memory_arbiter #(.DSTREAK_MAX(DMAX), .ADDR_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
   );

   always #5 CLK = ~CLK;

   int    n_chk = 0, n_pass = 0;
   bit    armed = 1'b0;
   int    owner = 0;      // 0 nobody, 1 fetch, 2 data
   int    streak = 0;
   bit    merr = 1'b0;
   int    run = 0, lat = 2;
   bit    man = 1'b0;
   string trace = "";

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chks(input string name, input string act, input string exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
   endtask

   // Ownership model: who holds the RAM, how many data grants in a row jumped a waiting fetch.
   always @(posedge CLK) begin
      if (nRST) begin
         owner = 0; streak = 0; merr = 1'b0;
      end else if (owner == 0) begin
         if ((dREN || dWEN) && (!iREN || streak < DMAX)) begin
            owner  = 2;
            streak = iREN ? ((streak + 1 > DMAX) ? DMAX : streak + 1) : 0;
         end else if (iREN) begin
            owner  = 1;
            streak = 0;
         end
      end else begin
         if ((owner == 1 && !iREN) || (owner == 2 && !(dREN || dWEN))) owner = 0;
         else if (ramstate == 2'd3) merr = 1'b1;
         else if (ramstate == 2'd2) owner = 0;
      end
   end

   int          eo;
   logic        e_ren, e_wen, e_iw, e_dw;
   logic [31:0] e_addr, e_store, e_il, e_dl;

   always @(negedge CLK) begin
      eo = nRST ? 0 : owner;
      e_ren = 0; e_wen = 0; e_iw = iREN; e_dw = dREN | dWEN;
      e_addr = '0; e_store = '0; e_il = '0; e_dl = '0;
      if (eo == 1 && iREN) begin
         e_ren = 1; e_addr = iaddr;
         if (ramstate == 2'd2) begin e_iw = 0; e_il = ramload; end
      end else if (eo == 2 && (dREN || dWEN)) begin
         e_wen = dWEN; e_ren = !dWEN; e_addr = daddr; e_store = dstore;
         if (ramstate == 2'd2) begin e_dw = 0; e_dl = ramload; end
      end
      if (armed) begin
         chk("m_ramREN", ramREN, e_ren);
         chk("m_ramWEN", ramWEN, e_wen);
         chk("m_iwait", iwait, e_iw);
         chk("m_dwait", dwait, e_dw);
         chk("m_iload", iload, e_il);
         chk("m_dload", dload, e_dl);
         chk("m_ram_err", ram_err, merr);
         if (e_ren || e_wen) chk("m_ramaddr", ramaddr, e_addr);
         if (e_wen) chk("m_ramstore", ramstore, e_store);
         if (iREN && !iwait) trace = {trace, "I"};
         if ((dREN || dWEN) && !dwait) trace = {trace, "D"};
      end
      if ((ramREN || ramWEN) && ramstate != 2'd2) run++;
      else run = 0;
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
      if (!man) ramstate = (run >= lat) ? 2'd2 : ((run > 0) ? 2'd1 : 2'd0);
   endtask

   task automatic mid();
      @(negedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1; iREN = 0; dREN = 0; dWEN = 0; man = 0; ramstate = 2'd0;
      cyc();
      armed = 1;
      cyc();
      nRST = 0;
      trace = "";
   endtask

   initial begin
      // 1: fetch with two-cycle RAM latency
      do_reset(); lat = 2; ramload = 32'hDEADBEEF; iaddr = 32'h100; iREN = 1;
      mid(); chk("t1_c0_iwait", iwait, 1); chk("t1_c0_ren", ramREN, 0);
      cyc(); mid(); chk("t1_c1_ren", ramREN, 1); chk("t1_c1_addr", ramaddr, 32'h100);
      cyc(); mid(); chk("t1_c2_iwait", iwait, 1);
      cyc(); mid(); chk("t1_c3_iwait", iwait, 0); chk("t1_c3_iload", iload, 32'hDEADBEEF);
      cyc(); iREN = 0; mid(); chk("t1_c4_ren", ramREN, 0); chk("t1_c4_iload", iload, 0);

      // 2: simultaneous fetch and write, data first
      do_reset(); lat = 2; ramload = 32'h55;
      iREN = 1; iaddr = 32'h200; dWEN = 1; daddr = 32'h40; dstore = 32'h12345678;
      cyc(); mid(); chk("t2_wen", ramWEN, 1); chk("t2_ren", ramREN, 0);
      chk("t2_addr", ramaddr, 32'h40); chk("t2_store", ramstore, 32'h12345678); chk("t2_iwait", iwait, 1);
      cyc(); cyc(); mid(); chk("t2_dwait", dwait, 0);
      cyc(); dWEN = 0; mid(); chk("t2_idle_ren", ramREN, 0); chk("t2_idle_wen", ramWEN, 0);
      cyc(); mid(); chk("t2_ig_ren", ramREN, 1); chk("t2_ig_addr", ramaddr, 32'h200);
      for (int i = 0; i < 10; i++) begin
         if (!iwait) break;
         cyc(); mid();
      end
      chk("t2_idone", iwait, 0);
      cyc(); iREN = 0;

      // 3: streak limit lets one fetch through after four data grants
      do_reset(); lat = 1; ramload = 32'hA5A50000; iaddr = 32'h300; daddr = 32'h80;
      iREN = 1; dREN = 1;
      for (int i = 0; i < 100 && trace.len() < 6; i++) begin cyc(); mid(); end
      chks("t3_order", trace, "DDDDID");
      cyc(); iREN = 0; dREN = 0;

      // 7: reset mid-streak restarts the count from zero
      do_reset(); lat = 1; iREN = 1; dREN = 1;
      for (int i = 0; i < 50 && trace.len() < 2; i++) begin cyc(); mid(); end
      chks("t7_pre", trace, "DD");
      cyc(); cyc(); nRST = 1; mid(); chk("t7_rst_ren", ramREN, 0);
      cyc(); nRST = 0; trace = "";
      for (int i = 0; i < 100 && trace.len() < 5; i++) begin cyc(); mid(); end
      chks("t7_post", trace, "DDDDI");
      cyc(); iREN = 0; dREN = 0;

      // 4: RAM error retried, then access
      do_reset(); man = 1; ramstate = 2'd0; dREN = 1; daddr = 32'h80; ramload = 32'hCAFEF00D;
      mid();
      cyc(); ramstate = 2'd3; mid(); chk("t4_c1_dwait", dwait, 1); chk("t4_c1_ren", ramREN, 1);
      chk("t4_c1_addr", ramaddr, 32'h80); chk("t4_c1_err", ram_err, 0);
      cyc(); ramstate = 2'd3; mid(); chk("t4_c2_dwait", dwait, 1); chk("t4_c2_err", ram_err, 1);
      cyc(); ramstate = 2'd3; mid(); chk("t4_c3_ren", ramREN, 1);
      cyc(); ramstate = 2'd2; mid(); chk("t4_c4_dwait", dwait, 0); chk("t4_c4_dload", dload, 32'hCAFEF00D);
      cyc(); dREN = 0; ramstate = 2'd0; mid(); chk("t4_c5_err", ram_err, 1); chk("t4_c5_ren", ramREN, 0);

      // 5: reset while a fetch is stalled on BUSY
      do_reset(); man = 1; ramstate = 2'd3; iREN = 1; dREN = 1; iaddr = 32'h300; daddr = 32'h84;
      cyc(); ramstate = 2'd3;
      cyc(); ramstate = 2'd2; mid(); chk("t5_err", ram_err, 1); chk("t5_ddone", dwait, 0);
      cyc(); dREN = 0; ramstate = 2'd1;
      cyc(); mid(); chk("t5_ig_ren", ramREN, 1); chk("t5_ig_iwait", iwait, 1);
      cyc(); nRST = 1; mid(); chk("t5_rst_ren", ramREN, 0);
      cyc(); nRST = 0; mid(); chk("t5_post_ren", ramREN, 0); chk("t5_post_wen", ramWEN, 0);
      chk("t5_post_iwait", iwait, 1); chk("t5_post_err", ram_err, 0);
      cyc(); iREN = 0;

      // 6: data request withdrawn mid-grant
      do_reset(); man = 1; ramstate = 2'd1; dREN = 1; daddr = 32'h44;
      cyc(); mid(); chk("t6_c1_ren", ramREN, 1);
      cyc(); dREN = 0; mid(); chk("t6_c2_ren", ramREN, 0); chk("t6_c2_dwait", dwait, 0); chk("t6_c2_dload", dload, 0);
      cyc(); ramstate = 2'd2; mid(); chk("t6_c3_ren", ramREN, 0); chk("t6_c3_wen", ramWEN, 0);
      cyc(); man = 0;
      chks("t6_nodone", trace, "");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
